// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - RV32A LR/SC/AMO load-compute-store sequencer for a multicycle core
// Holds the LR/SC reservation and drives the ALU decoder during the AMO compute step.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef AMO_OP_WIDTH
`define AMO_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 5'd0
`endif
`ifndef ALU_OP_AMO
`define ALU_OP_AMO 5'd20
`endif
`ifndef AMO_OP_ADD
`define AMO_OP_ADD  4'd0
`define AMO_OP_SWAP 4'd1
`define AMO_OP_LR   4'd2
`define AMO_OP_SC   4'd3
`define AMO_OP_XOR  4'd4
`define AMO_OP_AND  4'd5
`define AMO_OP_OR   4'd6
`define AMO_OP_MIN  4'd7
`define AMO_OP_MAX  4'd8
`define AMO_OP_MINU 4'd9
`define AMO_OP_MAXU 4'd10
`endif

module amo_sequencer #(
   parameter int RESV_ADDR_LSB = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [4:0]               funct5,
   input  logic [31:0]              addr,
   input  logic [31:0]              rs2,
   input  logic                     resv_clear,
   output logic                     busy,
   output logic                     done,
   output logic                     fault_misaligned,
   output logic                     fault_illegal,
   output logic                     mem_valid,
   output logic                     mem_wr,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_wstrb,
   input  logic                     mem_ready,
   input  logic [31:0]              mem_rdata,
   output logic [`ALU_OP_WIDTH-1:0] alu_op,
   output logic [`AMO_OP_WIDTH-1:0] amo_op,
   output logic [31:0]              alu_a,
   output logic [31:0]              alu_b,
   input  logic [31:0]              alu_result,
   output logic                     rd_we,
   output logic [31:0]              rd_wdata
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_STORE, S_DONE, S_FAULT} state_t;

   state_t                     r_state;
   logic                       r_busy, r_done, r_fault_mis, r_fault_ill;
   logic                       r_mem_valid, r_mem_wr;
   logic [31:0]                r_mem_addr, r_mem_wdata;
   logic [3:0]                 r_mem_wstrb;
   logic [`ALU_OP_WIDTH-1:0]   r_alu_op;
   logic [`AMO_OP_WIDTH-1:0]   r_amo_op;
   logic [31:0]                r_old, r_rs2, r_rd, r_rd_wdata;
   logic                       r_rd_we;
   logic [31:RESV_ADDR_LSB]    r_tag;
   logic                       r_resv_valid;
   logic [31:RESV_ADDR_LSB]    r_resv_addr;

   logic                       w_legal;
   logic [`AMO_OP_WIDTH-1:0]   w_code;
   logic                       w_resv_hit;

   always_comb begin
      w_legal = 1'b1;
      w_code  = `AMO_OP_ADD;
      case (funct5)
         5'b00010: w_code = `AMO_OP_LR;
         5'b00011: w_code = `AMO_OP_SC;
         5'b00001: w_code = `AMO_OP_SWAP;
         5'b00000: w_code = `AMO_OP_ADD;
         5'b00100: w_code = `AMO_OP_XOR;
         5'b01100: w_code = `AMO_OP_AND;
         5'b01000: w_code = `AMO_OP_OR;
         5'b10000: w_code = `AMO_OP_MIN;
         5'b10100: w_code = `AMO_OP_MAX;
         5'b11000: w_code = `AMO_OP_MINU;
         5'b11100: w_code = `AMO_OP_MAXU;
         default:  w_legal = 1'b0;
      endcase
   end

   // A same-cycle resv_clear must defeat an SC that would otherwise match.
   assign w_resv_hit = r_resv_valid && (r_resv_addr == addr[31:RESV_ADDR_LSB]) && !resv_clear;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fault_mis  <= 1'b0;
         r_fault_ill  <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wstrb  <= '0;
         r_alu_op     <= `ALU_OP_ADD;
         r_amo_op     <= '0;
         r_old        <= '0;
         r_rs2        <= '0;
         r_rd         <= '0;
         r_rd_we      <= 1'b0;
         r_rd_wdata   <= '0;
         r_tag        <= '0;
         r_resv_valid <= 1'b0;
         r_resv_addr  <= '0;
      end else begin
         r_done      <= 1'b0;
         r_rd_we     <= 1'b0;
         r_fault_mis <= 1'b0;
         r_fault_ill <= 1'b0;
         r_alu_op    <= `ALU_OP_ADD;
         case (r_state)
            S_IDLE: if (start) begin
               r_busy     <= 1'b1;
               r_amo_op   <= w_code;
               r_rs2      <= rs2;
               r_tag      <= addr[31:RESV_ADDR_LSB];
               r_mem_addr <= {addr[31:2], 2'b00};
               if (addr[1:0] != 2'b00) begin
                  r_state     <= S_FAULT;
                  r_fault_mis <= 1'b1;
               end else if (!w_legal) begin
                  r_state     <= S_FAULT;
                  r_fault_ill <= 1'b1;
               end else if (w_code == `AMO_OP_SC) begin
                  if (w_resv_hit) begin
                     r_state     <= S_STORE;
                     r_mem_valid <= 1'b1;
                     r_mem_wr    <= 1'b1;
                     r_mem_wstrb <= 4'hF;
                     r_mem_wdata <= rs2;
                     r_rd        <= 32'd0;
                  end else begin
                     r_state      <= S_DONE;
                     r_done       <= 1'b1;
                     r_rd_we      <= 1'b1;
                     r_rd_wdata   <= 32'd1;
                     r_resv_valid <= 1'b0;
                  end
               end else begin
                  r_state     <= S_LOAD;
                  r_mem_valid <= 1'b1;
                  r_mem_wr    <= 1'b0;
                  r_mem_wstrb <= 4'h0;
               end
            end
            S_LOAD: if (mem_ready) begin
               r_mem_valid <= 1'b0;
               r_old       <= mem_rdata;
               if (r_amo_op == `AMO_OP_LR) begin
                  r_state      <= S_DONE;
                  r_resv_valid <= 1'b1;
                  r_resv_addr  <= r_tag;
                  r_done       <= 1'b1;
                  r_rd_we      <= 1'b1;
                  r_rd_wdata   <= mem_rdata;
               end else begin
                  r_state  <= S_CALC;
                  r_alu_op <= `ALU_OP_AMO;
               end
            end
            S_CALC: begin
               r_state     <= S_STORE;
               r_mem_valid <= 1'b1;
               r_mem_wr    <= 1'b1;
               r_mem_wstrb <= 4'hF;
               r_mem_wdata <= (r_amo_op == `AMO_OP_SWAP) ? r_rs2 : alu_result;
               r_rd        <= r_old;
            end
            S_STORE: if (mem_ready) begin
               r_state     <= S_DONE;
               r_mem_valid <= 1'b0;
               r_mem_wr    <= 1'b0;
               r_mem_wstrb <= 4'h0;
               r_done      <= 1'b1;
               r_rd_we     <= 1'b1;
               r_rd_wdata  <= r_rd;
               if (r_amo_op == `AMO_OP_SC)
                  r_resv_valid <= 1'b0;
            end
            S_DONE, S_FAULT: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
         if (resv_clear)
            r_resv_valid <= 1'b0;
      end
   end

   assign busy             = r_busy;
   assign done             = r_done;
   assign fault_misaligned = r_fault_mis;
   assign fault_illegal    = r_fault_ill;
   assign mem_valid        = r_mem_valid;
   assign mem_wr           = r_mem_wr;
   assign mem_addr         = r_mem_addr;
   assign mem_wdata        = r_mem_wdata;
   assign mem_wstrb        = r_mem_wstrb;
   assign alu_op           = r_alu_op;
   assign amo_op           = r_amo_op;
   assign alu_a            = r_old;
   assign alu_b            = r_rs2;
   assign rd_we            = r_rd_we;
   assign rd_wdata         = r_rd_wdata;
endmodule

// File: tb/tb_amo_sequencer.sv
// tb/tb_amo_sequencer.sv - table-driven bench for amo_sequencer with a wait-state memory model
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif
`ifndef AMO_OP_WIDTH
`define AMO_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 5'd0
`endif
`ifndef ALU_OP_AMO
`define ALU_OP_AMO 5'd20
`endif
`ifndef AMO_OP_ADD
`define AMO_OP_ADD  4'd0
`define AMO_OP_SWAP 4'd1
`define AMO_OP_LR   4'd2
`define AMO_OP_SC   4'd3
`define AMO_OP_XOR  4'd4
`define AMO_OP_AND  4'd5
`define AMO_OP_OR   4'd6
`define AMO_OP_MIN  4'd7
`define AMO_OP_MAX  4'd8
`define AMO_OP_MINU 4'd9
`define AMO_OP_MAXU 4'd10
`endif

module tb_amo_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [4:0] funct5 = '0;
   logic [31:0] addr = '0, rs2 = '0;
   logic resv_clear = 1'b0;
   logic busy, done, fault_misaligned, fault_illegal, mem_valid, mem_wr, rd_we;
   logic [31:0] mem_addr, mem_wdata, alu_a, alu_b, rd_wdata;
   logic [3:0] mem_wstrb;
   logic mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [`ALU_OP_WIDTH-1:0] alu_op;
   logic [`AMO_OP_WIDTH-1:0] amo_op;
   logic [31:0] alu_result;

   amo_sequencer #(.RESV_ADDR_LSB(2)) dut (
      .clk(clk), .reset(reset), .start(start), .funct5(funct5), .addr(addr), .rs2(rs2),
      .resv_clear(resv_clear), .busy(busy), .done(done), .fault_misaligned(fault_misaligned),
      .fault_illegal(fault_illegal), .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .alu_op(alu_op), .amo_op(amo_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .rd_we(rd_we), .rd_wdata(rd_wdata));

   always #5 clk = ~clk;

   // Reference ALU; SWAP returns a poison value so the bypass is observable.
   always_comb begin
      case (amo_op)
         `AMO_OP_ADD:  alu_result = alu_a + alu_b;
         `AMO_OP_XOR:  alu_result = alu_a ^ alu_b;
         `AMO_OP_AND:  alu_result = alu_a & alu_b;
         `AMO_OP_OR:   alu_result = alu_a | alu_b;
         `AMO_OP_MIN:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
         `AMO_OP_MAX:  alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
         `AMO_OP_MINU: alu_result = (alu_a < alu_b) ? alu_a : alu_b;
         `AMO_OP_MAXU: alu_result = (alu_a > alu_b) ? alu_a : alu_b;
         default:      alu_result = 32'hBAD0BAD0;
      endcase
   end

   logic [31:0] mem [0:255];
   int bus_wait = 0;
   int wait_cnt = 0, bus_cycles = 0, load_cnt = 0, store_cnt = 0, stab_err = 0, aluop_cnt = 0;
   logic [31:0] last_waddr = '0, last_wdata = '0, s_addr = '0, s_wdata = '0;
   logic s_wr = 1'b0;
   logic [3:0] s_wstrb = '0;
   logic [`AMO_OP_WIDTH-1:0] aluop_code = '0;
   logic [31:0] alu_a_seen = '0, alu_b_seen = '0;

   always @(negedge clk) begin
      mem_ready = 1'b0;
      if (mem_valid) begin
         bus_cycles++;
         if (wait_cnt == 0) begin
            s_addr = mem_addr; s_wr = mem_wr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
         end else if ({mem_addr, mem_wr, mem_wdata, mem_wstrb} != {s_addr, s_wr, s_wdata, s_wstrb}) begin
            stab_err++;
         end
         if (mem_addr[1:0] != 2'b00 || (mem_wr ? (mem_wstrb != 4'hF) : (mem_wstrb != 4'h0)))
            stab_err++;
         if (wait_cnt >= bus_wait) begin
            mem_ready = 1'b1;
            wait_cnt  = 0;
            mem_rdata = mem[mem_addr[9:2]];
            if (mem_wr) begin
               store_cnt++; last_waddr = mem_addr; last_wdata = mem_wdata;
            end else begin
               load_cnt++;
            end
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      if (alu_op == `ALU_OP_AMO) begin
         aluop_cnt++; aluop_code = amo_op; alu_a_seen = alu_a; alu_b_seen = alu_b;
      end
   end

   int checks = 0, failures = 0;
   int got_lat, d_loads, d_stores, d_bus, d_aluop;
   logic [31:0] got_rd;
   logic got_rdwe, got_fmis, got_fill, got_busy;
   logic [4:0] got_after;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic run_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                         input int wt, input int clr_at);
      int l0, s0, b0, u0;
      bus_wait = wt;
      l0 = load_cnt; s0 = store_cnt; b0 = bus_cycles; u0 = aluop_cnt;
      got_lat = -1; got_rd = '0; got_rdwe = 0; got_fmis = 0; got_fill = 0; got_busy = 0;
      @(negedge clk);
      start = 1'b1; funct5 = f5; addr = a; rs2 = b;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0; funct5 = 5'b11111; addr = $urandom; rs2 = $urandom;
         end
         resv_clear = (k == clr_at);
         if (done || fault_misaligned || fault_illegal) begin
            got_lat = k; got_rd = rd_wdata; got_rdwe = rd_we;
            got_fmis = fault_misaligned; got_fill = fault_illegal; got_busy = busy;
            break;
         end
      end
      resv_clear = 1'b0;
      @(negedge clk);
      got_after = {busy, done, rd_we, fault_misaligned, fault_illegal};
      d_loads = load_cnt - l0; d_stores = store_cnt - s0;
      d_bus = bus_cycles - b0; d_aluop = aluop_cnt - u0;
      if (d_stores != 0) mem[last_waddr[9:2]] = last_wdata;
   endtask

   typedef struct {
      logic [4:0]  f5;
      logic [31:0] addr, rs2, mem0;
      int          wt, lat;
      logic [31:0] rd, wd;
      logic        fm, fi;
      logic [3:0]  code;
   } vec_t;

   function automatic vec_t mk(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] m, input int wt, input int lat,
                               input logic [31:0] rd, input logic [31:0] wd,
                               input logic fm, input logic fi, input logic [3:0] code);
      vec_t v;
      v.f5 = f5; v.addr = a; v.rs2 = b; v.mem0 = m; v.wt = wt; v.lat = lat;
      v.rd = rd; v.wd = wd; v.fm = fm; v.fi = fi; v.code = code;
      return v;
   endfunction

   localparam int NV = 12;
   vec_t tv [NV];
   logic flt;
   logic found;

   initial begin
      tv[0]  = mk(5'b00000, 32'h100, 32'd7,        32'd5,        0, 4,  32'd5,        32'd12,       0, 0, `AMO_OP_ADD);
      tv[1]  = mk(5'b00001, 32'h104, 32'hDEAD,     32'h1234,     0, 4,  32'h1234,     32'hDEAD,     0, 0, `AMO_OP_SWAP);
      tv[2]  = mk(5'b00100, 32'h108, 32'h0FF0,     32'hF0F0,     0, 4,  32'hF0F0,     32'hFF00,     0, 0, `AMO_OP_XOR);
      tv[3]  = mk(5'b01100, 32'h10C, 32'h0F0F0F0F, 32'hFF00FF00, 0, 4,  32'hFF00FF00, 32'h0F000F00, 0, 0, `AMO_OP_AND);
      tv[4]  = mk(5'b01000, 32'h110, 32'h0F00,     32'h00F0,     0, 4,  32'h00F0,     32'h0FF0,     0, 0, `AMO_OP_OR);
      tv[5]  = mk(5'b10000, 32'h114, 32'd3,        32'hFFFFFFFE, 0, 4,  32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0, `AMO_OP_MIN);
      tv[6]  = mk(5'b10100, 32'h118, 32'd3,        32'hFFFFFFFE, 0, 4,  32'hFFFFFFFE, 32'd3,        0, 0, `AMO_OP_MAX);
      tv[7]  = mk(5'b11000, 32'h11C, 32'd3,        32'hFFFFFFFE, 0, 4,  32'hFFFFFFFE, 32'd3,        0, 0, `AMO_OP_MINU);
      tv[8]  = mk(5'b11100, 32'h120, 32'd1,        32'hFFFFFFFF, 3, 10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, `AMO_OP_MAXU);
      tv[9]  = mk(5'b00001, 32'h102, 32'd9,        32'd0,        0, 1,  32'd0,        32'd0,        1, 0, `AMO_OP_SWAP);
      tv[10] = mk(5'b00101, 32'h100, 32'd9,        32'd0,        0, 1,  32'd0,        32'd0,        0, 1, `AMO_OP_ADD);
      tv[11] = mk(5'b00101, 32'h101, 32'd9,        32'd0,        0, 1,  32'd0,        32'd0,        1, 0, `AMO_OP_ADD);
      for (int i = 0; i < 256; i++) mem[i] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", {30'd0, busy, done, fault_misaligned, fault_illegal, mem_valid, mem_wr, rd_we}, 32'd0);
      chk("reset_bus", mem_addr | mem_wdata | {28'd0, mem_wstrb}, 32'd0);
      chk("reset_alu", alu_a | alu_b | rd_wdata | {23'd0, alu_op, amo_op}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         mem[tv[i].addr[9:2]] = tv[i].mem0;
         run_op(tv[i].f5, tv[i].addr, tv[i].rs2, tv[i].wt, 0);
         flt = tv[i].fm | tv[i].fi;
         chk($sformatf("row%0d_lat", i), got_lat, tv[i].lat);
         chk($sformatf("row%0d_fmis", i), {31'd0, got_fmis}, {31'd0, tv[i].fm});
         chk($sformatf("row%0d_fill", i), {31'd0, got_fill}, {31'd0, tv[i].fi});
         chk($sformatf("row%0d_rdwe", i), {31'd0, got_rdwe}, {31'd0, !flt});
         chk($sformatf("row%0d_stores", i), d_stores, flt ? 0 : 1);
         chk($sformatf("row%0d_buscyc", i), d_bus, flt ? 0 : 2 * (tv[i].wt + 1));
         chk($sformatf("row%0d_aluop", i), d_aluop, flt ? 0 : 1);
         chk($sformatf("row%0d_busy", i), {31'd0, got_busy}, 32'd1);
         chk($sformatf("row%0d_after", i), {27'd0, got_after}, 32'd0);
         if (!flt) begin
            chk($sformatf("row%0d_rd", i), got_rd, tv[i].rd);
            chk($sformatf("row%0d_wdata", i), last_wdata, tv[i].wd);
            chk($sformatf("row%0d_waddr", i), last_waddr, tv[i].addr);
            chk($sformatf("row%0d_code", i), {28'd0, aluop_code}, {28'd0, tv[i].code});
            chk($sformatf("row%0d_alu_a", i), alu_a_seen, tv[i].mem0);
            chk($sformatf("row%0d_alu_b", i), alu_b_seen, tv[i].rs2);
         end
      end

      // LR then SC pass, then a second SC fails
      mem[32'h200 >> 2] = 32'hAA;
      run_op(5'b00010, 32'h200, 32'd0, 0, 0);
      chk("lr_lat", got_lat, 2);
      chk("lr_rd", got_rd, 32'hAA);
      chk("lr_loads", d_loads, 1);
      chk("lr_stores", d_stores, 0);
      chk("lr_aluop", d_aluop, 0);
      run_op(5'b00011, 32'h200, 32'h55, 0, 0);
      chk("sc_pass_lat", got_lat, 2);
      chk("sc_pass_rd", got_rd, 32'd0);
      chk("sc_pass_stores", d_stores, 1);
      chk("sc_pass_wdata", last_wdata, 32'h55);
      chk("sc_pass_waddr", last_waddr, 32'h200);
      run_op(5'b00011, 32'h200, 32'h66, 0, 0);
      chk("sc_again_lat", got_lat, 1);
      chk("sc_again_rd", got_rd, 32'd1);
      chk("sc_again_bus", d_bus, 0);

      // resv_clear between LR and SC
      run_op(5'b00010, 32'h200, 32'd0, 0, 0);
      chk("lr2_rd", got_rd, 32'h55);
      @(negedge clk); resv_clear = 1'b1;
      @(negedge clk); resv_clear = 1'b0;
      run_op(5'b00011, 32'h200, 32'h77, 0, 0);
      chk("sc_clr_rd", got_rd, 32'd1);
      chk("sc_clr_bus", d_bus, 0);

      // address mismatch
      run_op(5'b00010, 32'h200, 32'd0, 0, 0);
      run_op(5'b00011, 32'h204, 32'h77, 0, 0);
      chk("sc_mismatch_rd", got_rd, 32'd1);
      chk("sc_mismatch_bus", d_bus, 0);

      // resv_clear in the same cycle the LR sets the reservation
      run_op(5'b00010, 32'h200, 32'd0, 0, 1);
      chk("lr_clr_lat", got_lat, 2);
      run_op(5'b00011, 32'h200, 32'h77, 0, 0);
      chk("sc_lrclr_rd", got_rd, 32'd1);

      // AMO between LR and SC leaves the reservation intact
      mem[32'h300 >> 2] = 32'd7;
      run_op(5'b00010, 32'h300, 32'd0, 0, 0);
      run_op(5'b00000, 32'h300, 32'd1, 0, 0);
      chk("amo_mid_rd", got_rd, 32'd7);
      chk("amo_mid_wdata", last_wdata, 32'd8);
      run_op(5'b00011, 32'h300, 32'd9, 0, 0);
      chk("sc_after_amo_rd", got_rd, 32'd0);
      chk("sc_after_amo_wdata", last_wdata, 32'd9);

      // reset during the STORE wait of an AMO
      mem[32'h100 >> 2] = 32'd1;
      run_op(5'b00010, 32'h100, 32'd0, 0, 0);
      bus_wait = 4;
      @(negedge clk);
      start = 1'b1; funct5 = 5'b00000; addr = 32'h100; rs2 = 32'd2;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (mem_valid && mem_wr) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("rst_store_seen", {31'd0, found}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_async", {29'd0, mem_valid, busy, done | rd_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mem_untouched", mem[32'h100 >> 2], 32'd1);
      run_op(5'b00011, 32'h100, 32'h44, 0, 0);
      chk("rst_sc_rd", got_rd, 32'd1);
      chk("rst_sc_lat", got_lat, 1);
      chk("rst_sc_bus", d_bus, 0);

      chk("bus_stable", stab_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/amo_sequencer.md
Name: amo_sequencer

Overview:
- Multicycle sequencer for RV32A (LR.W, SC.W, AMO*.W) in the kianv harris multicycle core.
- Dispatched by the main control FSM. Runs the load / ALU-compute / store sequence on the memory bus.
- Drives ALUOp = ALU_OP_AMO and AMOop into the ALU decoder during the compute step. Holds the LR/SC reservation.

Parameters:
RESV_ADDR_LSB, 2, lowest address bit compared for reservation match (word granule)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle dispatch pulse; ignored while busy
funct5  in  5  instr[31:27]
addr  in  32  rs1 value (effective address)
rs2  in  32  rs2 value
resv_clear  in  1  invalidate reservation (trap, xRET, foreign store)
busy  out  1  high from cycle after start until done/fault cycle inclusive
done  out  1  one-cycle completion pulse
fault_misaligned  out  1  one-cycle pulse, addr[1:0]!=0
fault_illegal  out  1  one-cycle pulse, unsupported funct5
mem_valid  out  1  bus request
mem_wr  out  1  1=store, 0=load
mem_addr  out  32  {addr[31:2],2'b00}
mem_wdata  out  32  store data
mem_wstrb  out  4  4'hF on store, 0 on load
mem_ready  in  1  bus completion; mem_rdata valid same cycle
mem_rdata  in  32  load data
alu_op  out  `ALU_OP_WIDTH  ALU_OP_AMO in CALC, else ALU_OP_ADD
amo_op  out  `AMO_OP_WIDTH  AMO code decoded from funct5
alu_a  out  32  loaded value
alu_b  out  32  rs2
alu_result  in  32  combinational ALU result
rd_we  out  1  register write strobe, coincident with done
rd_wdata  out  32  rd value

Behaviour:
- Reset values: all outputs 0; state IDLE; reservation invalid; internal regs 0. Reset mid-operation aborts at once: mem_valid drops asynchronously, no done, no rd write.
- funct5 decode:
  - 00010 LR; 00011 SC; 00001 SWAP; 00000 ADD; 00100 XOR; 01100 AND; 01000 OR.
  - 10000 MIN; 10100 MAX; 11000 MINU; 11100 MAXU.
  - Any other value is illegal.
- Inputs latched on start; later input changes have no effect on the operation.
- States: IDLE, LOAD, CALC, STORE, DONE, FAULT.
- IDLE on start:
  - Misaligned -> FAULT. Misalignment has priority over illegal.
  - Illegal -> FAULT.
  - LR or AMO -> LOAD.
  - SC with reservation valid, address match on addr[31:RESV_ADDR_LSB], and resv_clear low that cycle -> STORE.
  - SC otherwise -> DONE with rd=1.
- FAULT: pulse the matching fault output for one cycle, no bus access, reservation unchanged -> IDLE.
- LOAD:
  - mem_valid=1, mem_wr=0; hold until mem_ready.
  - On mem_ready, capture mem_rdata as old.
  - LR: set reservation {valid, addr} -> DONE with rd=old.
  - AMO -> CALC.
- CALC (1 cycle):
  - alu_op=ALU_OP_AMO, amo_op per funct5, alu_a=old, alu_b=rs2.
  - Capture new=alu_result, except SWAP captures new=rs2 (ALU bypassed).
  - -> STORE.
- STORE:
  - mem_valid=1, mem_wr=1, mem_wstrb=4'hF, mem_wdata=new (rs2 for SC); hold until mem_ready.
  - -> DONE; rd=old for AMO, rd=0 for SC.
- DONE (1 cycle): done=1, rd_we=1, rd_wdata=rd -> IDLE.
- Bus rule: while mem_valid=1 and mem_ready=0, mem_addr, mem_wr, mem_wdata and mem_wstrb are stable. mem_valid deasserts the cycle after mem_ready. Registered outputs only.
- Reservation:
  - Cleared by any SC completion, pass or fail.
  - Cleared by resv_clear in any state. resv_clear beats a same-cycle LR set.
  - A new LR overwrites the reservation address.
  - AMO ops do not affect the reservation.
- Latency with zero-wait bus (start at T):
  - LR done at T+2.
  - AMO done at T+4.
  - SC pass done at T+2.
  - SC fail done at T+1.
  - Fault pulse at T+1.
  - Each mem wait cycle adds 1.

Test Plan:
- AMOADD.W addr=0x100, mem[0x100]=5, rs2=7, zero-wait -> load then store 12 to 0x100, rd_wdata=5, done at T+4, alu_op=ALU_OP_AMO during CALC only.
- LR.W 0x200 (mem=0xAA) then SC.W 0x200 rs2=0x55 -> LR rd=0xAA; SC stores 0x55, rd=0; second SC.W 0x200 -> no store, rd=1.
- LR.W 0x200, pulse resv_clear, SC.W 0x200 -> fails, rd=1, no bus activity. LR 0x200 then SC 0x204 -> fails, rd=1.
- AMOMAXU.W mem=0xFFFFFFFF, rs2=1 with mem_ready delayed 3 cycles on each access -> stores 0xFFFFFFFF, rd=0xFFFFFFFF, request fields stable while waiting, done at T+10.
- AMOSWAP.W addr=0x102 -> fault_misaligned pulse at T+1, no mem_valid, no rd_we. funct5=00101 at 0x100 -> fault_illegal pulse only.
- Assert reset during the STORE wait of an AMO -> mem_valid low immediately, busy=0, reservation invalid. A subsequent SC fails with rd=1.
